// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, BCD constants and pow10 helper for bin2bcd_serial.
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [3:0] BCD_BLANK  = 4'hF;
   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_ADD    = 4'd3;
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: add-3 correction applied to one BCD work nibble before each shift.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial shift-add-3 binary to packed BCD converter with overflow blanking.
// Leading-zero blanking is compiled in with BIN2BCD_BLANK_EN.
module bin2bcd_serial
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd_out
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("bin2bcd_serial: WIDTH must be 1..32");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bin2bcd_serial: DIGITS must be 1..8");
   end

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [4*DIGITS-1:0] work_q, work_d, adj, fmt;
   logic                ovfp_q, ovfp_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (.d(work_q[4*g +: 4]), .q(adj[4*g +: 4]));
   end

`ifdef BIN2BCD_BLANK_EN
   logic seen;
   always_comb begin
      seen = 1'b0;
      fmt  = work_q;
      for (int i = DIGITS - 1; i > 0; i--) begin
         seen = seen | (work_q[4*i +: 4] != 4'd0);
         if (!seen) fmt[4*i +: 4] = BCD_BLANK;
      end
   end
`else
   assign fmt = work_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      work_d  = work_q;
      ovfp_d  = ovfp_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bin_d   = bin_in;
            work_d  = '0;
            ovfp_d  = 64'(bin_in) > LIMIT;
         end
         SHIFT: begin
            work_d  = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
            bin_d   = bin_q << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = ovfp_q;
            bcd_d   = ovfp_q ? {DIGITS{BCD_BLANK}} : fmt;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         work_q  <= '0;
         ovfp_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         work_q  <= work_d;
         ovfp_q  <= ovfp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign bcd_out = bcd_q;
endmodule
